// File: rtl/data_nxn_transform.sv
// N x N element-matrix permutation (pass / transpose / rotate CW / rotate CCW)
// feeding a 2-entry output FIFO with valid/ready back-pressure on both sides.
module data_nxn_transform #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*N*W-1:0]   in_data,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*N*W-1:0]   out_data,
  output logic [CNT_W-1:0]   beat_cnt
);

  localparam int unsigned D = N * N * W;

  wire  [D-1:0] w_perm;
  logic         w_accept;
  logic         w_release;

  logic [D-1:0]     r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_beat_cnt;

  // Permutation network: each output element selects one of four fixed sources.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int unsigned DST = r * N + c;
      localparam int unsigned TRN = c * N + r;
      localparam int unsigned RCW = (N - 1 - c) * N + r;
      localparam int unsigned RCC = c * N + (N - 1 - r);
      assign w_perm[DST*W +: W] = (in_mode == 2'b00) ? in_data[DST*W +: W] :
                                  (in_mode == 2'b01) ? in_data[TRN*W +: W] :
                                  (in_mode == 2'b10) ? in_data[RCW*W +: W] :
                                                       in_data[RCC*W +: W];
    end
  end

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // FIFO storage, pointers, occupancy and accepted-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= w_perm;
        r_wptr        <= ~r_wptr;
        r_beat_cnt    <= r_beat_cnt + CNT_W'(1);
      end
      if (w_release) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_accept, w_release})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Handshake flags decode occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rptr];
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_data_nxn_transform.sv
// Bench for data_nxn_transform: default 4x4x8 instance plus a 3x3x4 instance
// with a 4-bit beat counter, both checked every cycle against a queue model.
module tb_data_nxn_transform;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [127:0] a_in_data = '0;
  logic [1:0]   a_in_mode = 2'b00;
  logic         a_out_valid;
  logic         a_out_ready = 1'b0;
  logic [127:0] a_out_data;
  logic [15:0]  a_beat_cnt;

  // Instance B: N=3, W=4, CNT_W=4
  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [35:0]  b_in_data = '0;
  logic [1:0]   b_in_mode = 2'b00;
  logic         b_out_valid;
  logic         b_out_ready = 1'b0;
  logic [35:0]  b_out_data;
  logic [3:0]   b_beat_cnt;

  data_nxn_transform u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .beat_cnt(a_beat_cnt)
  );

  data_nxn_transform #(.W(4), .N(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .beat_cnt(b_beat_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic rnd_en = 1'b0;

  // Model state
  logic [127:0] qa[$];
  logic [127:0] qb[$];
  logic [15:0]  cnta = '0;
  logic [3:0]   cntb = '0;
  logic [127:0] loga[$];
  int           logc[$];
  logic [127:0] logb[$];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Element (r,c) at bits (r*n+c)*w; o(r,c) pulled from the source cell the mode names.
  function automatic logic [127:0] perm(input logic [127:0] x, input logic [1:0] m,
                                        input int n, input int w);
    logic [127:0] o;
    int sr, sc;
    o = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        case (m)
          2'b00:   begin sr = r;         sc = c;         end
          2'b01:   begin sr = c;         sc = r;         end
          2'b10:   begin sr = n - 1 - c; sc = r;         end
          default: begin sr = c;         sc = n - 1 - r; end
        endcase
        for (int b = 0; b < w; b++) o[(r*n+c)*w+b] = x[(sr*n+sc)*w+b];
      end
    end
    return o;
  endfunction

  // Compare A against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic acc, rel;
    cyc++;
    if (rst) begin
      qa.delete();
      cnta = '0;
      chk("a_rst_data", a_out_data, 128'h0);
    end
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("a_beat_cnt", a_beat_cnt, cnta);
    if (qa.size() != 0) chk("a_out_data", a_out_data, qa[0]);
    if (!rst) begin
      rel = (qa.size() != 0) && a_out_ready;
      acc = a_in_valid && (qa.size() < 2);
      if (rel) begin
        loga.push_back(qa[0]);
        logc.push_back(cyc);
        void'(qa.pop_front());
      end
      if (acc) begin
        qa.push_back(perm(a_in_data, a_in_mode, 4, 8));
        cnta = cnta + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic acc, rel;
    if (rst) begin
      qb.delete();
      cntb = '0;
    end
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    chk("b_in_ready", b_in_ready, qb.size() < 2);
    chk("b_beat_cnt", b_beat_cnt, cntb);
    if (qb.size() != 0) chk("b_out_data", b_out_data, qb[0]);
    if (!rst) begin
      rel = (qb.size() != 0) && b_out_ready;
      acc = b_in_valid && (qb.size() < 2);
      if (rel) begin
        logb.push_back(qb[0]);
        void'(qb.pop_front());
      end
      if (acc) begin
        qb.push_back(perm({92'h0, b_in_data}, b_in_mode, 3, 4));
        cntb = cntb + 4'd1;
      end
    end
  end

  // Pseudo-random downstream back-pressure for A
  always begin
    @(posedge clk);
    #1;
    if (rnd_en) a_out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_a(input logic [127:0] d, input logic [1:0] m);
    int t;
    logic rdy;
    a_in_data  = d;
    a_in_mode  = m;
    a_in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      rdy = a_in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        chk("a_send_timeout", 128'h1, 128'h0);
        break;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [35:0] d, input logic [1:0] m);
    int t;
    logic rdy;
    b_in_data  = d;
    b_in_mode  = m;
    b_in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      rdy = b_in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        chk("b_send_timeout", 128'h1, 128'h0);
        break;
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int t;
    a_out_ready = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (!a_out_valid) break;
      t++;
      if (t > 1000) begin
        chk("a_drain_timeout", 128'h1, 128'h0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] SEQ_IN = 128'h0f0e0d0c0b0a09080706050403020100;

  initial begin
    logic [127:0] exp4 [4];
    logic [127:0] bb [3];
    exp4[0] = SEQ_IN;
    exp4[1] = 128'h0f0b07030e0a06020d0905010c080400;
    exp4[2] = 128'h03070b0f02060a0e0105090d0004080c;
    exp4[3] = 128'h0c0804000d0905010e0a06020f0b0703;

    // Literal pins on the reference permutation
    for (int m = 0; m < 4; m++) chk("model_perm4", perm(SEQ_IN, 2'(m), 4, 8), exp4[m]);
    chk("model_perm3_tr", perm(128'h876543210, 2'b01, 3, 4), 128'h852741630);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // First beat, transpose, 1-cycle latency
    a_out_ready = 1'b1;
    send_a(128'h01010101020202020303030304040404, 2'b01);
    @(negedge clk);
    chk("t1_valid", a_out_valid, 128'h1);
    chk("t1_data", a_out_data, 128'h01020304010203040102030401020304);
    chk("t1_cnt", a_beat_cnt, 128'd1);
    @(posedge clk);
    #1;

    // Four modes back to back
    loga.delete();
    logc.delete();
    for (int m = 0; m < 4; m++) send_a(SEQ_IN, 2'(m));
    drain_a();
    chk("t2_count", loga.size(), 128'd4);
    for (int k = 0; k < 4 && k < loga.size(); k++) chk("t2_data", loga[k], exp4[k]);
    for (int k = 1; k < 4 && k < logc.size(); k++) chk("t2_nobubble", logc[k] - logc[k-1], 128'd1);

    // Stall with two beats buffered, third held off
    loga.delete();
    bb[0] = 128'h00112233445566778899aabbccddeeff;
    bb[1] = 128'hdeadbeef0123456789abcdeffedcba98;
    bb[2] = 128'h55aa55aa33cc33cc0ff00ff012345678;
    a_out_ready = 1'b0;
    send_a(bb[0], 2'b10);
    send_a(bb[1], 2'b11);
    a_in_data  = bb[2];
    a_in_mode  = 2'b01;
    a_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_full_ready", a_in_ready, 128'h0);
      chk("t3_hold_data", a_out_data, perm(bb[0], 2'b10, 4, 8));
      chk("t3_hold_cnt", a_beat_cnt, 128'd7);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    send_a(bb[2], 2'b01);
    drain_a();
    chk("t3_count", loga.size(), 128'd3);
    if (loga.size() == 3) begin
      chk("t3_ord0", loga[0], perm(bb[0], 2'b10, 4, 8));
      chk("t3_ord1", loga[1], perm(bb[1], 2'b11, 4, 8));
      chk("t3_ord2", loga[2], perm(bb[2], 2'b01, 4, 8));
    end
    chk("t3_cnt", a_beat_cnt, 128'd8);

    // 200 beats with random back-pressure
    loga.delete();
    rnd_en = 1'b1;
    for (int i = 0; i < 200; i++)
      send_a({$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
    rnd_en = 1'b0;
    drain_a();
    chk("t4_count", loga.size(), 128'd200);
    chk("t4_cnt", a_beat_cnt, 128'd208);

    // Asynchronous reset while full
    a_out_ready = 1'b0;
    send_a(bb[0], 2'b00);
    send_a(bb[1], 2'b00);
    @(negedge clk);
    chk("t5_pre_full", a_in_ready, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", a_out_valid, 128'h0);
    chk("t5_rst_cnt", a_beat_cnt, 128'h0);
    chk("t5_rst_data", a_out_data, 128'h0);
    chk("t5_rst_ready", a_in_ready, 128'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    send_a(SEQ_IN, 2'b11);
    @(negedge clk);
    chk("t5_lat_valid", a_out_valid, 128'h1);
    chk("t5_lat_data", a_out_data, exp4[3]);
    chk("t5_lat_cnt", a_beat_cnt, 128'd1);
    @(posedge clk);
    #1;

    // Small instance: pass/transpose and 4-bit counter wrap over 17 beats
    logb.delete();
    b_out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      if (i == 1)      send_b(36'h876543210, 2'b01);
      else if (i == 2) send_b(36'h876543210, 2'b00);
      else             send_b(36'($urandom()) ^ {$urandom_range(0, 15), 32'h0}, 2'(i % 2));
      @(negedge clk);
      if (i == 1)  chk("t6_tr_data", b_out_data, 128'h852741630);
      if (i == 2)  chk("t6_pass_data", b_out_data, 128'h876543210);
      if (i == 15) chk("t6_cnt15", b_beat_cnt, 128'd15);
      if (i == 16) chk("t6_cnt_wrap", b_beat_cnt, 128'd0);
      if (i == 17) chk("t6_cnt_end", b_beat_cnt, 128'd1);
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t6_count", logb.size(), 128'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
